// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a byte-addressed data memory.
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a request, memory bus quiet
// RD    | memory read of the latched address, word captured at exit
// WR    | full-word write of merged data (RMW or plain word store)
// RESP  | response presented until resp_ready

module dmem_access_ctrl #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 4);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rword_q;

    logic              misalign;
    logic              req_err;
    logic              accept;
    logic [31:0]       merged;
    logic [31:0]       load_ext;
    logic              sgn;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (req_size == 2'b11) || (req_addr > ADDR_MAX) || misalign;
    assign accept  = (state == ST_IDLE) && req_valid;

    // Store lanes replace only the low bytes of the word fetched in RD.
    always_comb begin
        merged = wdata_q;
        case (size_q)
            2'b00:   merged = {rword_q[31:8], wdata_q[7:0]};
            2'b01:   merged = {rword_q[31:16], wdata_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        load_ext = rword_q;
        sgn      = 1'b0;
        case (size_q)
            2'b00: begin
                sgn      = ~uns_q & rword_q[7];
                load_ext = {{24{sgn}}, rword_q[7:0]};
            end
            2'b01: begin
                sgn      = ~uns_q & rword_q[15];
                load_ext = {{16{sgn}}, rword_q[15:0]};
            end
            default: load_ext = rword_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = resetn;
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = ST_RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_re    = 1'b1;
                mem_addr  = addr_q;
                state_nxt = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : load_ext;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rword_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state == ST_RD) begin
                rword_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a byte-array reference model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design build.

module tb_dmem_access_ctrl;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 32;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    logic [7:0] dut_mem [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];
    logic       mem_init;

    int n_chk;
    int n_pass;

    dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: 4-byte write on posedge, read data refreshed on negedge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) dut_mem[i] <= 8'h00;
            dut_mem[1] <= 8'h05;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (32'(mem_addr) + 32'(i) < 32'(MEM_BYTES))
                    dut_mem[32'(mem_addr) + 32'(i)] <= mem_wdata[8*i +: 8];
        end
    end

    always @(negedge clk) begin
        if (mem_re) begin
            for (int i = 0; i < 4; i++)
                mem_rdata[8*i +: 8] <= (32'(mem_addr) + 32'(i) < 32'(MEM_BYTES)) ?
                                       dut_mem[32'(mem_addr) + 32'(i)] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[a + i];
        return w;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input logic early, output logic [31:0] rd);
        logic        exp_err;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
        int          nb;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        int          lat;
        int          re_n;
        int          we_n;
        logic        got;
        logic [31:0] wd_seen;
        logic [31:0] addr_seen;
        logic [31:0] mask;

        exp_err = (size == 2'b11) || (addr > 32'(MEM_BYTES - 4));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) exp_err = 1'b1;
`endif
        nb      = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_rd  = 32'h0;
        exp_wd  = 32'h0;
        if (exp_err)       exp_lat = 1;
        else if (!we)      exp_lat = 2;
        else if (nb == 4)  exp_lat = 2;
        else               exp_lat = 3;
        exp_re = (!exp_err && (!we || nb != 4)) ? 1 : 0;
        exp_we = (!exp_err && we) ? 1 : 0;
        if (!exp_err && !we) begin
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_mem[int'(addr) + i];
            if (!uns && nb < 4 && exp_rd[8*nb-1]) begin
                mask   = (32'h1 << (8*nb)) - 32'h1;
                exp_rd = exp_rd | ~mask;
            end
        end
        if (!exp_err && we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            exp_wd = ref_word(int'(addr));
        end

        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        resp_ready   = early;
        @(negedge clk);
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;

        lat = 0; re_n = 0; we_n = 0; got = 1'b0;
        wd_seen = 32'h0; addr_seen = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_re) begin re_n++; addr_seen = mem_addr; end
            if (mem_we) begin we_n++; wd_seen = mem_wdata; addr_seen = mem_addr; end
            if (resp_valid) begin
                lat = k;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("resp_timeout", 32'(resp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("mem_re_cycles", 32'(re_n), 32'(exp_re));
        chk("mem_we_cycles", 32'(we_n), 32'(exp_we));
        if (exp_re + exp_we > 0) chk("mem_addr", addr_seen, addr);
        if (exp_we > 0) chk("mem_wdata", wd_seen, exp_wd);
        rd = resp_rdata;

        if (!early) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_rdata", resp_rdata, exp_rd);
                chk("hold_err", 32'(resp_err), 32'(exp_err));
                chk("hold_req_ready", 32'(req_ready), 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          mism;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;

        n_chk = 0; n_pass = 0;
        mem_init = 1'b1;
        resetn = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        ref_mem[1] = 8'h05;

        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_re_we", {30'h0, mem_re, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        chk("rel_resp_rdata", resp_rdata, 32'h0);
        chk("rel_resp_err", 32'(resp_err), 32'd0);

        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0, rd);
        chk("lw0_const", rd, 32'h0000_0500);
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 1, 1'b0, rd);
        do_req(1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_00AB, 0, 1'b0, rd);
        chk("sb_rdata_const", rd, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0, rd);
        chk("lw_after_sb_const", rd, 32'h1122_33AB);
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_8001, 0, 1'b0, rd);
        do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 0, 1'b0, rd);
        chk("lh_const", rd, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 0, 1'b0, rd);
        chk("lhu_const", rd, 32'h0000_8001);
        do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 0, 1'b0, rd);
        chk("lbu_const", rd, 32'h0000_0080);
        do_req(1'b0, 2'b10, 1'b0, 32'h3FD, 32'h0, 3, 1'b0, rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, rd);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 3, 1'b0, rd);
        do_req(1'b1, 2'b11, 1'b0, 32'h4, 32'hDEAD_BEEF, 0, 1'b0, rd);

        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 0, 1'b0, rd);
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h5566_7788, 0, 1'b0, rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, 1'b0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_misalign_trap", 32'(resp_err), 32'd0);
`else
        chk("lw_misalign_const", rd, 32'h7788_1122);
`endif

        // Reset while the RMW read of an SH is in flight.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 0, 1'b0, rd);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_in_rd", 32'(mem_re), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rstmid_mem_re", 32'(mem_re), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rstmid_rel_ready", 32'(req_ready), 32'd1);
        chk("rstmid_rel_valid", 32'(resp_valid), 32'd0);
        chk("rstmid_word10", {dut_mem[19], dut_mem[18], dut_mem[17], dut_mem[16]}, ref_word(16));
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd);
        chk("rstmid_lw_const", rd, 32'hCAFE_F00D);

        for (int t = 0; t < 300; t++) begin
            we   = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 4));
                default: addr = 32'($urandom_range(0, 63));
            endcase
            do_req(we, size, 1'($urandom), addr, $urandom, $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0), rd);
        end

        mism = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
        chk("mem_final", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store sequencer between the MEM pipeline stage and the byte-addressed data memory.
- Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory read/write cycles. The memory always writes 4 bytes, so sub-word stores run as read-modify-write.
- Performs sign/zero extension and range checking, and returns results over a valid/ready response handshake. The pipeline stalls while req_ready=0.

Parameters:
MEM_BYTES, 1024, memory size in bytes; legal access window is addr 0..MEM_BYTES-4.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word/stores
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, low bytes used for sub-word
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  access rejected, memory untouched
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  32  to memory writeData
mem_we  out  1  to memory writeEnable
mem_re  out  1  to memory readEnable
mem_rdata  in  32  from memory readData (updates on falling edge while mem_re=1)

Behaviour:
- Interface: one clock clk; reset resetn is asynchronous, active-low.
- Request latch: a request is accepted on a posedge with req_valid && req_ready. At that edge, addr/size/we/unsigned/wdata are latched and used for the rest of the operation.
- Error check at accept: error if size==11 or addr > MEM_BYTES-4. On error: go to RESP with resp_err=1 and issue no memory access.
- States:
  - IDLE: req_ready=1.
  - RD: mem_re=1, mem_addr=latched addr. mem_rdata is captured into a register at the closing posedge.
  - WR: mem_we=1. mem_wdata is the captured read word with byte lanes [8*n-1:0] replaced by req_wdata lanes; n=1 for byte, 2 for half, 4 for word.
  - RESP: resp_valid=1; outputs held stable until resp_ready.
- Transitions:
  - IDLE→RD on accepted load or sub-word store.
  - IDLE→WR on accepted word store (no read).
  - IDLE→RESP on error.
  - RD→RESP for loads; RD→WR for sub-word stores.
  - WR→RESP.
  - RESP→IDLE when resp_ready. A new request can be accepted only in the following IDLE cycle, so back-to-back issue gap is one cycle.
- Latency (accept edge = cycle 0): load resp_valid in cycle 2; SW in cycle 2; SB/SH in cycle 3; error in cycle 1.
- Load data, little-endian from the captured word:
  - Byte: bits [7:0]; half: [15:0]; word: all 32 bits.
  - Sign-extend unless req_unsigned.
- Outputs outside their active state: mem_re, mem_we, mem_addr, mem_wdata are 0 outside RD/WR (mem_addr 0 in IDLE).
- Reset values: state IDLE, req_ready=1 after reset release (0 during reset), resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: asynchronously returns to IDLE and drops mem_we/mem_re immediately. No partial write is committed, because the memory samples the write on posedge. Pending response is discarded.
- resp_ready asserted outside RESP is ignored. req_valid while busy is ignored; the requester holds it.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a half at odd addr, or a word with addr[1:0]!=0, is an error. It is treated like a range error: RESP in cycle 1, resp_err=1, no memory access.
- Undefined: any alignment is permitted; the memory's byte indexing handles it.

Test Plan:
- After reset (memory mem[1]=0x05): LW addr 0x0 → resp_rdata 0x00000500, resp_valid in cycle 2, mem_re high exactly 1 cycle.
- Word 0x0 holds 0x11223344; SB wdata 0x000000AB addr 0x0 → RD then WR with mem_wdata 0x112233AB. resp_valid in cycle 3, resp_rdata 0, resp_err 0. Follow-up LW returns 0x112233AB.
- SW 0x00008001 addr 0x8 then LH addr 0x8 → 0xFFFF8001; LHU addr 0x8 → 0x00008001; LBU addr 0x9 → 0x00000080.
- LW addr 0x3FD (MEM_BYTES=1024) → resp_err=1 in cycle 1, mem_re/mem_we never asserted. size=11 → same. Hold resp_ready=0 for 3 cycles → resp_valid/resp_err stay stable, req_ready=0.
- With DMEM_MISALIGN_TRAP_EN: LW addr 0x2 → resp_err=1. Without it: LW addr 0x2 after SW 0x11223344@0x0 and SW 0x55667788@0x4 → 0x77881122.
- SH addr 0x10: assert resetn=0 during RD → mem_re drops immediately, no WR occurs, word 0x10 unchanged, resp_valid=0. req_ready=1 after release.
